// File: rtl/hyper_stream_writer.sv
// rtl/hyper_stream_writer.sv - FIFO-buffered pixel stream to Wishbone incrementing write bursts
// Drains a show-ahead FIFO into a linearly addressed, wrapping frame buffer.
module hyper_stream_writer #(
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          enable_i,
   input  logic [31:0]   frame_base_i,
   input  logic [23:0]   frame_words_i,
   input  logic [31:0]   s_dat_i,
   input  logic          s_valid_i,
   output logic          s_ready_o,
   output logic [31:0]   wb_adr_o,
   output logic [31:0]   wb_dat_o,
   output logic [3:0]    wb_sel_o,
   output logic [2:0]    wb_cti_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   input  logic          wb_ack_i,
   output logic          frame_done_o,
   output logic [LW-1:0] fifo_level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [23:0]     offset_q, offset_d, fwords_q, fwords_d;
   logic [31:0]     base_q, base_d, adr_q, adr_d;
   logic [BW-1:0]   beat_q, beat_d, blen_q, blen_d;
   logic [2:0]      cti_q, cti_d;
   logic            cyc_q, cyc_d, stb_q, stb_d, done_q, done_d;

   logic            push, pop;
   logic [23:0]     fw_eff, rem, blen_ext;
   logic [31:0]     base_eff;
   logic [BW-1:0]   blen_new;

   assign s_ready_o    = (level_q < LW'(FIFO_DEPTH));
   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = stb_q ? mem_q[rd_ptr_q] : 32'd0;
   assign wb_sel_o     = 4'hF;
   assign wb_cti_o     = cti_q;
   assign wb_we_o      = cyc_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = stb_q;
   assign frame_done_o = done_q;
   assign fifo_level_o = level_q;

   always_comb begin
      push     = s_valid_i && s_ready_o;
      pop      = stb_q && wb_ack_i;
      // Frame geometry is taken live only at the start of a frame, then held.
      fw_eff   = (offset_q == 24'd0) ? frame_words_i : fwords_q;
      base_eff = (offset_q == 24'd0) ? (frame_base_i & 32'hFFFF_FFFC) : base_q;
      rem      = fw_eff - offset_q;
      blen_new = (rem < 24'(BURST_LEN)) ? BW'(rem) : BW'(BURST_LEN);
      blen_ext = 24'(blen_new);

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);

      state_d  = state_q;
      offset_d = offset_q;
      fwords_d = fwords_q;
      base_d   = base_q;
      adr_d    = adr_q;
      beat_d   = beat_q;
      blen_d   = blen_q;
      cti_d    = cti_q;
      cyc_d    = cyc_q;
      stb_d    = stb_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i && (frame_words_i != 24'd0) && (24'(level_q) >= blen_ext)) begin
               state_d  = ST_BURST;
               cyc_d    = 1'b1;
               stb_d    = 1'b1;
               cti_d    = (blen_new > BW'(1)) ? 3'b010 : 3'b000;
               adr_d    = base_eff + 32'({offset_q, 2'b00});
               base_d   = base_eff;
               fwords_d = fw_eff;
               blen_d   = blen_new;
               beat_d   = '0;
            end
         end
         ST_BURST: begin
            if (wb_ack_i) begin
               adr_d    = adr_q + 32'd4;
               beat_d   = beat_q + BW'(1);
               offset_d = offset_q + 24'd1;
               if (beat_q == blen_q - BW'(1)) begin
                  state_d = ST_GAP;
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  cti_d   = 3'b000;
                  if (offset_q + 24'd1 == fwords_q) begin
                     offset_d = 24'd0;
                     done_d   = 1'b1;
                  end
               end else if (beat_q + BW'(1) == blen_q - BW'(1)) begin
                  cti_d = 3'b111;
               end
            end
         end
         ST_GAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q] <= s_dat_i;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         offset_q <= '0;
         fwords_q <= '0;
         base_q   <= '0;
         adr_q    <= '0;
         beat_q   <= '0;
         blen_q   <= '0;
         cti_q    <= 3'b000;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         offset_q <= offset_d;
         fwords_q <= fwords_d;
         base_q   <= base_d;
         adr_q    <= adr_d;
         beat_q   <= beat_d;
         blen_q   <= blen_d;
         cti_q    <= cti_d;
         cyc_q    <= cyc_d;
         stb_q    <= stb_d;
         done_q   <= done_d;
      end
   end

endmodule
